num: RTL and testbench

- Implements the MIX NUM instruction, the inverse of CHAR.
- Takes ten 6-bit MIX character codes (rA:rX, 60 bits) and reduces each to a decimal digit (code mod 10).
- Accumulates the digits most-significant first into a 30-bit binary magnitude.
- Sits beside the char unit in the execute datapath and uses the same start/stop pulse handshake.

---
 rtl/num_pkg.sv | 13 +
 rtl/num_digit10.sv | 11 +
 rtl/num.sv | 92 +++++++++
 tb/tb_num.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/num_pkg.sv
// Shared MIX constants and types for the NUM (character-to-binary) unit.
package num_pkg;
  localparam int CHAR_W     = 6;
  localparam int WORD_CHARS = 5;
  localparam int WORD_W     = CHAR_W * WORD_CHARS;
  localparam int NUM_CHARS  = 10;
  localparam int IN_W       = CHAR_W * NUM_CHARS;
  localparam int ACC_W      = WORD_W + 4;
  localparam int CNT_W      = 4;
  localparam logic [CHAR_W-1:0] DIGIT_BASE = 6'd30;

  typedef enum logic {IDLE, RUN} state_e;
endpackage

// File: rtl/num_digit10.sv
// digit10: maps a 6-bit MIX character code to its decimal digit (code mod 10).
module digit10
  import num_pkg::*;
(
  input  logic [CHAR_W-1:0] code,
  output logic [3:0]        digit
);
  logic [CHAR_W-1:0] rem;
  assign rem   = code % CHAR_W'(10);
  assign digit = rem[3:0];
endmodule

// File: rtl/num.sv
// MIX NUM: folds ten characters (rA:rX) MSB-first into a 30-bit magnitude.
// Define NUM_OVERFLOW_EN to add the sticky ovf output.
module num
  import num_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [IN_W-1:0]   in,
  output logic              stop,
  output logic [WORD_W-1:0] out
`ifdef NUM_OVERFLOW_EN
  , output logic            ovf
`endif
);
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [IN_W-1:0]    shift_q, shift_d;
  logic [WORD_W-1:0]  acc_q, acc_d;
  logic               stop_q, stop_d;
  logic [3:0]         d;
  logic [ACC_W-1:0]   acc_ext, prod;

  digit10 u_digit (.code(shift_q[IN_W-1 -: CHAR_W]), .digit(d));

  // acc*10 + d as shift-add, kept at full width so the wrap is observable
  assign acc_ext = {{(ACC_W-WORD_W){1'b0}}, acc_q};
  assign prod    = (acc_ext << 3) + (acc_ext << 1) + ACC_W'(d);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    shift_d = shift_q;
    acc_d   = acc_q;
    stop_d  = 1'b0;
    if (start) begin
      state_d = RUN;
      count_d = '0;
      shift_d = in;
      acc_d   = '0;
    end else if (state_q == RUN) begin
      acc_d   = prod[WORD_W-1:0];
      shift_d = shift_q << CHAR_W;
      count_d = count_q + 4'd1;
      if (count_q == CNT_W'(NUM_CHARS - 1)) begin
        state_d = IDLE;
        stop_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      shift_q <= '0;
      acc_q   <= '0;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      shift_q <= shift_d;
      acc_q   <= acc_d;
      stop_q  <= stop_d;
    end
  end

  assign stop = stop_q;
  assign out  = acc_q;

`ifdef NUM_OVERFLOW_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (start)
      ovf_d = 1'b0;
    else if (state_q == RUN)
      ovf_d = ovf_q | (|prod[ACC_W-1:WORD_W]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`else
  logic unused_hi;
  assign unused_hi = |prod[ACC_W-1:WORD_W];
`endif
endmodule

// File: tb/tb_num.sv
// Scoreboard bench for num: expected results queued at start, checked on stop.
module tb_num;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [59:0] in_r = '0;
  logic        stop;
  logic [29:0] out;
`ifdef NUM_OVERFLOW_EN
  logic        ovf;
`endif

  typedef struct {
    logic [29:0] val;
    logic        ovf;
    int          due;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  num dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in(in_r), .stop(stop), .out(out)
`ifdef NUM_OVERFLOW_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [59:0] v, input int due);
    exp_t e;
    longint acc = 0;
    logic [5:0] c;
    e.ovf = 1'b0;
    for (int i = 9; i >= 0; i--) begin
      c = v[i*6 +: 6];
      acc = acc * 10 + longint'(c % 10);
      if (acc >= 64'd1073741824) begin
        e.ovf = 1'b1;
        acc = acc % 64'd1073741824;
      end
    end
    e.val = acc[29:0];
    e.due = due;
    return e;
  endfunction

  function automatic logic [59:0] pack(input int c0, c1, c2, c3, c4, c5, c6, c7, c8, c9);
    return {c0[5:0], c1[5:0], c2[5:0], c3[5:0], c4[5:0],
            c5[5:0], c6[5:0], c7[5:0], c8[5:0], c9[5:0]};
  endfunction

  // Scoreboard: every stop must match the oldest pending conversion.
  always @(negedge clk) begin
    if (rst_n && stop) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_stop cyc=%0d out=%0d", cyc, out);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (out !== e.val || cyc != e.due) begin
          bad++;
          $display("FAIL stop_result out=%0d want=%0d cyc=%0d want_cyc=%0d", out, e.val, cyc, e.due);
        end
`ifdef NUM_OVERFLOW_EN
        total++;
        if (ovf !== e.ovf) begin
          bad++;
          $display("FAIL ovf got=%0b want=%0b", ovf, e.ovf);
        end
`endif
      end
    end
  end

  // Call just after a posedge; start is sampled at the following edge.
  task automatic do_start(input logic [59:0] v, input bit abort);
    if (abort) q.delete();
    in_r  = v;
    start = 1'b1;
    q.push_back(model(v, cyc + 1 + 10));
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (q.size() != 0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL %s timeout pending=%0d want=0", name, q.size());
      q.delete();
    end
  endtask

  task automatic test_reset();
    #3;
    total++;
    if (out !== 30'd0) begin bad++; $display("FAIL reset_out got=%0d want=0", out); end
    total++;
    if (stop !== 1'b0) begin bad++; $display("FAIL reset_stop got=%0b want=0", stop); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_knuth();
    do_start(pack(0, 0, 31, 32, 39, 37, 57, 47, 30, 30), 0);
    wait_done("knuth");
  endtask

  task automatic test_digits_hold();
    do_start(pack(30, 31, 32, 33, 34, 35, 36, 37, 38, 39), 0);
    wait_done("digits");
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      total++;
      if (out !== 30'd123456789) begin
        bad++;
        $display("FAIL hold out=%0d want=123456789 i=%0d", out, i);
      end
    end
  endtask

  task automatic test_nines();
    do_start(pack(39, 39, 39, 39, 39, 39, 39, 39, 39, 39), 0);
    wait_done("nines");
  endtask

  task automatic test_reset_mid();
    do_start(pack(30, 31, 32, 33, 34, 35, 36, 37, 38, 39), 0);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    q.delete();
    #1;
    total++;
    if (out !== 30'd0) begin bad++; $display("FAIL midreset_out got=%0d want=0", out); end
    total++;
    if (stop !== 1'b0) begin bad++; $display("FAIL midreset_stop got=%0b want=0", stop); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    do_start('0, 0);
    wait_done("zero_after_reset");
  endtask

  task automatic test_abort();
    do_start(pack(30, 31, 32, 33, 34, 35, 36, 37, 38, 39), 0);
    repeat (3) @(posedge clk);
    #1;
    do_start(pack(12, 12, 12, 12, 12, 12, 12, 12, 12, 12), 1);
    wait_done("abort");
  endtask

  task automatic test_back_to_back();
    int n = 0;
    do_start('0, 0);
    while (stop !== 1'b1 && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (stop !== 1'b1) begin
      bad++;
      $display("FAIL b2b_first_stop got=%0b want=1", stop);
    end
    do_start(pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 15), 0);
    wait_done("back_to_back");
  endtask

  initial begin
    test_reset();
    test_knuth();
    test_digits_hold();
    test_nines();
    test_reset_mid();
    test_abort();
    test_back_to_back();
    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
